// File: rtl/sync_lutram_fifo_mc.sv
// Multi-channel synchronous FIFO: NCHAN independent queues share one distributed RAM,
// each queue keeping its own pointers, occupancy, flags and sticky error bits.
module sync_lutram_fifo_mc #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 16,
  parameter int NCHAN  = 4,
  parameter int AFULL  = 14,
  parameter int DOREG  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DWIDTH-1:0]                    din,
  input  logic                                 we,
  input  logic [$clog2(NCHAN)-1:0]             wch,
  input  logic                                 re,
  input  logic [$clog2(NCHAN)-1:0]             rch,
  output logic [DWIDTH-1:0]                    dout,
  output logic                                 rvalid,
  output logic [NCHAN-1:0]                     empty,
  output logic [NCHAN-1:0]                     full,
  output logic [NCHAN-1:0]                     afull,
  output logic [NCHAN*($clog2(DEPTH)+1)-1:0]   count,
  output logic [NCHAN-1:0]                     ovf,
  output logic [NCHAN-1:0]                     udf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(NCHAN);
  localparam int NW = AW + 1;

  logic [DWIDTH-1:0] ram_r [NCHAN*DEPTH];
  logic [AW-1:0]     head_r [NCHAN];
  logic [AW-1:0]     tail_r [NCHAN];
  logic [NW-1:0]     count_r [NCHAN];
  logic [NW-1:0]     count_nxt_s [NCHAN];
  logic [NCHAN-1:0]  empty_r, full_r, afull_r, ovf_r, udf_r;
  logic              acc_w_s, acc_r_s;
  logic [CW+AW-1:0]  wr_addr_s, rd_addr_s;
  logic [DWIDTH-1:0] rd_data_s;

  assign acc_w_s   = we & ~full_r[wch];
  assign acc_r_s   = re & ~empty_r[rch];
  assign wr_addr_s = {wch, tail_r[wch]};
  assign rd_addr_s = {rch, head_r[rch]};
  assign rd_data_s = ram_r[rd_addr_s];

  // Shared storage: never reset, written only by accepted enqueues outside reset.
  always_ff @(posedge clk) begin
    if (acc_w_s && !rst) begin
      ram_r[wr_addr_s] <= din;
    end
  end

  // Next occupancy per channel; an enqueue and dequeue on the same channel cancel out.
  always_comb begin
    for (int c = 0; c < NCHAN; c++) begin
      count_nxt_s[c] = count_r[c];
      case ({acc_w_s && (wch == CW'(c)), acc_r_s && (rch == CW'(c))})
        2'b10:   count_nxt_s[c] = count_r[c] + NW'(1);
        2'b01:   count_nxt_s[c] = count_r[c] - NW'(1);
        default: count_nxt_s[c] = count_r[c];
      endcase
    end
  end

  // Pointers, counters, registered flags and sticky error bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCHAN; c++) begin
        head_r[c]  <= {AW{1'b0}};
        tail_r[c]  <= {AW{1'b0}};
        count_r[c] <= {NW{1'b0}};
      end
      empty_r <= {NCHAN{1'b1}};
      full_r  <= {NCHAN{1'b0}};
      afull_r <= {NCHAN{1'b0}};
      ovf_r   <= {NCHAN{1'b0}};
      udf_r   <= {NCHAN{1'b0}};
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        count_r[c] <= count_nxt_s[c];
        empty_r[c] <= (count_nxt_s[c] == NW'(0));
        full_r[c]  <= (count_nxt_s[c] == NW'(DEPTH));
        afull_r[c] <= (count_nxt_s[c] >= NW'(AFULL));
      end
      if (acc_w_s) tail_r[wch] <= tail_r[wch] + AW'(1);
      if (acc_r_s) head_r[rch] <= head_r[rch] + AW'(1);
      if (we && full_r[wch]) ovf_r[wch] <= 1'b1;
      if (re && empty_r[rch]) udf_r[rch] <= 1'b1;
    end
  end

  generate
    if (DOREG != 0) begin : g_doreg
      logic [DWIDTH-1:0] dout_r;
      logic              rvalid_r;
      // Output register tracks the pre-increment head of the selected channel every cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_r   <= {DWIDTH{1'b0}};
          rvalid_r <= 1'b0;
        end else begin
          dout_r   <= rd_data_s;
          rvalid_r <= acc_r_s;
        end
      end
      assign dout   = dout_r;
      assign rvalid = rvalid_r;
    end else begin : g_fwft
      assign dout   = rd_data_s;
      assign rvalid = acc_r_s;
    end

    for (genvar g = 0; g < NCHAN; g++) begin : g_count
      assign count[g*NW +: NW] = count_r[g];
    end
  endgenerate

  assign empty = empty_r;
  assign full  = full_r;
  assign afull = afull_r;
  assign ovf   = ovf_r;
  assign udf   = udf_r;

  a_flags_exclusive: assert property (@(posedge clk) disable iff (rst)
    (empty_r & full_r) == {NCHAN{1'b0}});

endmodule

// File: tb/tb_sync_lutram_fifo_mc.sv
// Directed bench: vector table for the DOREG=1 instance, hand sequences for reset
// mid-fill and the DOREG=0 peek path.
module tb_sync_lutram_fifo_mc;
  logic        clk, rst;
  logic [31:0] din;
  logic        we, re;
  logic [1:0]  wch, rch;
  logic [31:0] dout, dout0;
  logic        rvalid, rvalid0;
  logic [3:0]  empty, full, afull, ovf, udf;
  logic [3:0]  empty0, full0, afull0, ovf0, udf0;
  logic [19:0] count, count0;
  int tests = 0;
  int fails = 0;

  sync_lutram_fifo_mc #(.DWIDTH(32), .DEPTH(16), .NCHAN(4), .AFULL(14), .DOREG(1)) u_dut (
    .clk(clk), .rst(rst), .din(din), .we(we), .wch(wch), .re(re), .rch(rch),
    .dout(dout), .rvalid(rvalid), .empty(empty), .full(full), .afull(afull),
    .count(count), .ovf(ovf), .udf(udf));

  sync_lutram_fifo_mc #(.DWIDTH(32), .DEPTH(16), .NCHAN(4), .AFULL(14), .DOREG(0)) u_dut0 (
    .clk(clk), .rst(rst), .din(din), .we(we), .wch(wch), .re(re), .rch(rch),
    .dout(dout0), .rvalid(rvalid0), .empty(empty0), .full(full0), .afull(afull0),
    .count(count0), .ovf(ovf0), .udf(udf0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  wch;
    logic [31:0] din;
    logic        re;
    logic [1:0]  rch;
    logic        rv;
    logic [31:0] dout;
    logic [3:0]  empty, full, afull;
    logic [19:0] cnt;
    logic [3:0]  ovf, udf;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [19:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
  endfunction

  function automatic void add(input logic w, input logic [1:0] wc, input logic [31:0] d,
                              input logic r, input logic [1:0] rc, input logic rv,
                              input logic [31:0] dq, input logic [3:0] e, input logic [3:0] f,
                              input logic [3:0] af, input logic [19:0] cn,
                              input logic [3:0] ov, input logic [3:0] ud);
    vec_t v;
    v.we = w; v.wch = wc; v.din = d; v.re = r; v.rch = rc; v.rv = rv; v.dout = dq;
    v.empty = e; v.full = f; v.afull = af; v.cnt = cn; v.ovf = ov; v.udf = ud;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Fill ch2 with 0x100..0x10F
    for (int i = 0; i < 16; i++)
      add(1'b1, 2'd2, 32'h100 + 32'(i), 1'b0, 2'd0, 1'b0, 32'h0, 4'b1011,
          (i == 15) ? 4'b0100 : 4'b0000, (i + 1 >= 14) ? 4'b0100 : 4'b0000,
          pk(0, 0, i + 1, 0), 4'b0000, 4'b0000);
    // Drain ch2 in order
    for (int i = 0; i < 16; i++)
      add(1'b0, 2'd0, 32'h0, 1'b1, 2'd2, 1'b1, 32'h100 + 32'(i),
          (i == 15) ? 4'b1111 : 4'b1011, 4'b0000, (15 - i >= 14) ? 4'b0100 : 4'b0000,
          pk(0, 0, 15 - i, 0), 4'b0000, 4'b0000);
    // Interleave ch0/ch1
    add(1'b1, 2'd0, 32'hA0, 1'b0, 2'd0, 1'b0, 32'h0, 4'b1110, 4'b0, 4'b0, pk(1, 0, 0, 0), 4'b0, 4'b0);
    add(1'b1, 2'd1, 32'hB0, 1'b0, 2'd0, 1'b0, 32'h0, 4'b1100, 4'b0, 4'b0, pk(1, 1, 0, 0), 4'b0, 4'b0);
    add(1'b1, 2'd0, 32'hA1, 1'b0, 2'd0, 1'b0, 32'h0, 4'b1100, 4'b0, 4'b0, pk(2, 1, 0, 0), 4'b0, 4'b0);
    add(1'b1, 2'd1, 32'hB1, 1'b0, 2'd0, 1'b0, 32'h0, 4'b1100, 4'b0, 4'b0, pk(2, 2, 0, 0), 4'b0, 4'b0);
    add(1'b0, 2'd0, 32'h0, 1'b1, 2'd1, 1'b1, 32'hB0, 4'b1100, 4'b0, 4'b0, pk(2, 1, 0, 0), 4'b0, 4'b0);
    add(1'b0, 2'd0, 32'h0, 1'b1, 2'd0, 1'b1, 32'hA0, 4'b1100, 4'b0, 4'b0, pk(1, 1, 0, 0), 4'b0, 4'b0);
    add(1'b0, 2'd0, 32'h0, 1'b1, 2'd1, 1'b1, 32'hB1, 4'b1110, 4'b0, 4'b0, pk(1, 0, 0, 0), 4'b0, 4'b0);
    add(1'b0, 2'd0, 32'h0, 1'b1, 2'd0, 1'b1, 32'hA1, 4'b1111, 4'b0, 4'b0, pk(0, 0, 0, 0), 4'b0, 4'b0);
    // ch3: 5 entries, then 20 cycles of simultaneous enqueue/dequeue through wrap, then drain
    for (int i = 0; i < 5; i++)
      add(1'b1, 2'd3, 32'h300 + 32'(i), 1'b0, 2'd0, 1'b0, 32'h0, 4'b0111, 4'b0, 4'b0,
          pk(0, 0, 0, i + 1), 4'b0, 4'b0);
    for (int k = 0; k < 20; k++)
      add(1'b1, 2'd3, 32'h305 + 32'(k), 1'b1, 2'd3, 1'b1, 32'h300 + 32'(k), 4'b0111, 4'b0, 4'b0,
          pk(0, 0, 0, 5), 4'b0, 4'b0);
    for (int k = 0; k < 5; k++)
      add(1'b0, 2'd0, 32'h0, 1'b1, 2'd3, 1'b1, 32'h314 + 32'(k), (k == 4) ? 4'b1111 : 4'b0111,
          4'b0, 4'b0, pk(0, 0, 0, 4 - k), 4'b0, 4'b0);
    // Refill ch2, then error and same-slot corner cases
    for (int i = 0; i < 16; i++)
      add(1'b1, 2'd2, 32'h200 + 32'(i), 1'b0, 2'd0, 1'b0, 32'h0, 4'b1011,
          (i == 15) ? 4'b0100 : 4'b0000, (i + 1 >= 14) ? 4'b0100 : 4'b0000,
          pk(0, 0, i + 1, 0), 4'b0000, 4'b0000);
    add(1'b1, 2'd2, 32'hDEAD, 1'b0, 2'd0, 1'b0, 32'h0, 4'b1011, 4'b0100, 4'b0100, pk(0, 0, 16, 0), 4'b0100, 4'b0000);
    add(1'b0, 2'd0, 32'h0, 1'b1, 2'd0, 1'b0, 32'h0, 4'b1011, 4'b0100, 4'b0100, pk(0, 0, 16, 0), 4'b0100, 4'b0001);
    add(1'b1, 2'd2, 32'hBAD, 1'b1, 2'd2, 1'b1, 32'h200, 4'b1011, 4'b0000, 4'b0100, pk(0, 0, 15, 0), 4'b0100, 4'b0001);
    add(1'b1, 2'd1, 32'h55, 1'b1, 2'd1, 1'b0, 32'h0, 4'b1001, 4'b0000, 4'b0100, pk(0, 1, 15, 0), 4'b0100, 4'b0011);
    add(1'b0, 2'd0, 32'h0, 1'b1, 2'd1, 1'b1, 32'h55, 4'b1011, 4'b0000, 4'b0100, pk(0, 0, 15, 0), 4'b0100, 4'b0011);
    add(1'b0, 2'd0, 32'h0, 1'b1, 2'd2, 1'b1, 32'h201, 4'b1011, 4'b0000, 4'b0100, pk(0, 0, 14, 0), 4'b0100, 4'b0011);

    rst = 1'b1; we = 1'b0; re = 1'b0; wch = 2'd0; rch = 2'd0; din = 32'h0;
    tick();
    tick();
    chk("rst_empty", 0, 64'(empty), 64'hF);
    chk("rst_full", 0, 64'(full), 64'h0);
    chk("rst_afull", 0, 64'(afull), 64'h0);
    chk("rst_count", 0, 64'(count), 64'h0);
    chk("rst_ovf_udf", 0, 64'({ovf, udf}), 64'h0);
    chk("rst_rvalid", 0, 64'(rvalid), 64'h0);
    chk("rst_dout", 0, 64'(dout), 64'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      we = vecs[i].we; wch = vecs[i].wch; din = vecs[i].din;
      re = vecs[i].re; rch = vecs[i].rch;
      tick();
      chk("rvalid", i, 64'(rvalid), 64'(vecs[i].rv));
      if (vecs[i].rv) chk("dout", i, 64'(dout), 64'(vecs[i].dout));
      chk("empty", i, 64'(empty), 64'(vecs[i].empty));
      chk("full", i, 64'(full), 64'(vecs[i].full));
      chk("afull", i, 64'(afull), 64'(vecs[i].afull));
      chk("count", i, 64'(count), 64'(vecs[i].cnt));
      chk("ovf", i, 64'(ovf), 64'(vecs[i].ovf));
      chk("udf", i, 64'(udf), 64'(vecs[i].udf));
    end
    we = 1'b0; re = 1'b0;

    // Reset asserted mid-fill of ch1 with a write in the reset cycle
    for (int i = 0; i < 7; i++) begin
      we = 1'b1; wch = 2'd1; din = 32'h700 + 32'(i);
      tick();
    end
    chk("midfill_count1", 0, 64'(count[9:5]), 64'd7);
    rst = 1'b1; din = 32'h777;
    tick();
    rst = 1'b0; we = 1'b0;
    chk("mrst_count", 0, 64'(count), 64'h0);
    chk("mrst_empty", 0, 64'(empty), 64'hF);
    chk("mrst_full_afull", 0, 64'({full, afull}), 64'h0);
    chk("mrst_ovf_udf", 0, 64'({ovf, udf}), 64'h0);
    chk("mrst_rvalid_dout", 0, 64'({rvalid, dout}), 64'h0);
    tick();
    chk("mrst_drop_count", 0, 64'(count), 64'h0);
    chk("mrst_drop_empty", 0, 64'(empty), 64'hF);

    // Combinational peek path after reset
    we = 1'b1; wch = 2'd1; din = 32'hABC; re = 1'b0; rch = 2'd1;
    tick();
    we = 1'b0;
    chk("fwft_empty", 0, 64'(empty0), 64'b1101);
    chk("fwft_peek", 0, 64'(dout0), 64'hABC);
    chk("fwft_rvalid_idle", 0, 64'(rvalid0), 64'h0);
    re = 1'b1;
    #1;
    chk("fwft_rvalid", 0, 64'(rvalid0), 64'h1);
    chk("fwft_dout", 0, 64'(dout0), 64'hABC);
    tick();
    re = 1'b0;
    chk("fwft_drained", 0, 64'({empty0, count0}), 64'({4'hF, 20'h0}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
